// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the ID issue controller: FSM encoding and RISC-V register field positions.
package id_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned RS1_LSB   = 15;
  localparam int unsigned RS2_LSB   = 20;
  localparam int unsigned RD_LSB    = 7;
  // Wide enough for MAX_OUT up to 15.
  localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/id_scoreboard.sv
// Register busy scoreboard and outstanding-instruction counter; produces the issue hazard
// from registered state only.
module id_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_wb_block,
  input  logic                 i_issue,
  input  logic                 i_set_en,
  input  logic [REG_IDX_W-1:0] i_set_rd,
  input  logic                 i_wb_valid,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  input  logic                 i_use_rs1,
  input  logic                 i_use_rs2,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  output logic                 o_hazard
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_d;
  logic [CNT_W-1:0]    r_out_cnt;
  logic [CNT_W-1:0]    w_out_cnt_d;
  logic                w_wb;

  assign w_wb = i_wb_valid & ~i_wb_block;

  always_comb begin
    w_busy_d = r_busy;
    if (w_wb) w_busy_d[i_wb_rd] = 1'b0;
    // Set after clear so a same-cycle issue to the retiring register keeps it busy.
    if (i_set_en) w_busy_d[i_set_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
    if (i_clear) w_busy_d = '0;
  end

  always_comb begin
    w_out_cnt_d = r_out_cnt;
    if (i_clear) begin
      w_out_cnt_d = '0;
    end else if (i_issue && !w_wb) begin
      w_out_cnt_d = r_out_cnt + 1'b1;
    end else if (!i_issue && w_wb && (r_out_cnt != '0)) begin
      w_out_cnt_d = r_out_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_out_cnt <= '0;
    end else begin
      r_busy    <= w_busy_d;
      r_out_cnt <= w_out_cnt_d;
    end
  end

  assign o_hazard = (i_use_rs1 & r_busy[i_rs1]) | (i_use_rs2 & r_busy[i_rs2]) |
                    (r_out_cnt == CNT_W'(MAX_OUT));

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: one-entry holding slot, RAW/occupancy stall and branch flush.
// Optional ID_ISSUE_CTRL_PERF_EN adds a 32-bit stall_cycles counter output.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [WIDTH-1:0]     if_inst,
  output logic                 if_ready,
  output logic                 id_valid,
  output logic [WIDTH-1:0]     id_inst,
  input  logic                 id_ready,
  input  logic                 dec_use_rs1,
  input  logic                 dec_use_rs2,
  input  logic                 dec_rd_we,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 flush,
  output logic                 stall
`ifdef ID_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  state_e               r_state;
  state_e               w_state_d;
  logic                 r_hold_valid;
  logic [WIDTH-1:0]     r_hold_inst;
  logic                 w_hazard;
  logic                 w_issue;
  logic                 w_load;
  logic [REG_IDX_W-1:0] w_rs1;
  logic [REG_IDX_W-1:0] w_rs2;
  logic [REG_IDX_W-1:0] w_rd;

  assign w_rs1   = r_hold_inst[RS1_LSB +: REG_IDX_W];
  assign w_rs2   = r_hold_inst[RS2_LSB +: REG_IDX_W];
  assign w_rd    = r_hold_inst[RD_LSB +: REG_IDX_W];
  assign id_inst = r_hold_inst;

  always_comb begin
    w_state_d = r_state;
    id_valid  = 1'b0;
    stall     = 1'b0;
    case (r_state)
      StRun: begin
        // Flush withdraws the offer so EX never accepts an instruction being discarded.
        id_valid = r_hold_valid & ~w_hazard & ~flush;
        stall    = r_hold_valid & w_hazard;
        if (r_hold_valid && w_hazard) w_state_d = StStall;
      end
      StStall: begin
        stall = 1'b1;
        if (!w_hazard) w_state_d = StRun;
      end
      StFlush: w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
    if (flush) w_state_d = StFlush;
  end

  assign w_issue  = id_valid & id_ready;
  assign if_ready = (r_state != StFlush) & ~flush & (~r_hold_valid | w_issue);
  assign w_load   = if_valid & if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StRun;
      r_hold_valid <= 1'b0;
      r_hold_inst  <= '0;
    end else begin
      r_state <= w_state_d;
      if (flush) begin
        r_hold_valid <= 1'b0;
      end else if (w_load) begin
        r_hold_valid <= 1'b1;
        r_hold_inst  <= if_inst;
      end else if (w_issue) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  id_scoreboard #(
    .MAX_OUT(MAX_OUT)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (flush),
    .i_wb_block(r_state == StFlush),
    .i_issue   (w_issue),
    .i_set_en  (w_issue & dec_rd_we & (w_rd != '0)),
    .i_set_rd  (w_rd),
    .i_wb_valid(wb_valid),
    .i_wb_rd   (wb_rd),
    .i_use_rs1 (dec_use_rs1),
    .i_use_rs2 (dec_use_rs2),
    .i_rs1     (w_rs1),
    .i_rs2     (w_rs2),
    .o_hazard  (w_hazard)
  );

`ifdef ID_ISSUE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed, table-driven bench for id_issue_ctrl (default build, MAX_OUT = 4).
module tb_id_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        id_ready;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic        dec_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        if_valid;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        e_id_valid;
    logic        e_if_ready;
    logic        e_stall;
    logic [31:0] e_id_inst;
  } vec_t;

  vec_t tbl[$];

  id_issue_ctrl #(
    .WIDTH  (32),
    .MAX_OUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_ready   (if_ready),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_ready   (id_ready),
    .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2),
    .dec_rd_we  (dec_rd_we),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal decoder for the held instruction: OP-IMM reads rs1, OP reads rs1/rs2, both write rd.
  always_comb begin
    dec_use_rs1 = (id_inst[6:0] == 7'h13) || (id_inst[6:0] == 7'h33);
    dec_use_rs2 = (id_inst[6:0] == 7'h33);
    dec_rd_we   = dec_use_rs1;
  end

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic vec_t mk(input logic ifv, input logic [31:0] inst, input logic idr,
                              input logic wbv, input logic [4:0] wbr, input logic fl,
                              input logic ev, input logic er, input logic es,
                              input logic [31:0] ei);
    vec_t v;
    v.if_valid = ifv; v.if_inst = inst; v.id_ready = idr; v.wb_valid = wbv; v.wb_rd = wbr;
    v.flush = fl; v.e_id_valid = ev; v.e_if_ready = er; v.e_stall = es; v.e_id_inst = ei;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    if_valid = v.if_valid;
    if_inst  = v.if_inst;
    id_ready = v.id_ready;
    wb_valid = v.wb_valid;
    wb_rd    = v.wb_rd;
    flush    = v.flush;
    #1;
    chk({tag, ".id_valid"}, idx, 32'(id_valid), 32'(v.e_id_valid));
    chk({tag, ".if_ready"}, idx, 32'(if_ready), 32'(v.e_if_ready));
    chk({tag, ".stall"}, idx, 32'(stall), 32'(v.e_stall));
    if (v.e_id_valid) chk({tag, ".id_inst"}, idx, id_inst, v.e_id_inst);
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; if_inst = '0; id_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".id_valid"}, 0, 32'(id_valid), 32'd0);
    chk({tag, ".stall"}, 0, 32'(stall), 32'd0);
    chk({tag, ".if_ready"}, 0, 32'(if_ready), 32'd1);
    chk({tag, ".id_inst"}, 0, id_inst, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] i1, i2, i3, i4, i5, w5, w6, r7, r6, r8, xw, xr, ia, ib;
    i1 = addi(5'd1, 5'd0);  i2 = addi(5'd2, 5'd0);  i3 = addi(5'd3, 5'd0);
    i4 = addi(5'd4, 5'd0);  i5 = addi(5'd6, 5'd0);  w5 = addi(5'd5, 5'd0);
    w6 = addi(5'd6, 5'd0);  r7 = add(5'd7, 5'd5, 5'd0);
    r6 = add(5'd7, 5'd6, 5'd0);  r8 = add(5'd8, 5'd5, 5'd0);
    xw = addi(5'd0, 5'd0);  xr = add(5'd8, 5'd0, 5'd0);
    ia = addi(5'd9, 5'd0);  ib = addi(5'd10, 5'd0);

    //            ifv inst id_rdy wbv wbr fl | id_valid if_ready stall id_inst
    // Back-to-back, then 5th independent instruction hits the MAX_OUT limit.
    tbl.push_back(mk(1, i1, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, i2, 1, 0, 0, 0, 1, 1, 0, i1));
    tbl.push_back(mk(1, i3, 1, 0, 0, 0, 1, 1, 0, i2));
    tbl.push_back(mk(1, i4, 1, 0, 0, 0, 1, 1, 0, i3));
    tbl.push_back(mk(1, i5, 1, 0, 0, 0, 1, 1, 0, i4));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, i5));
    // RAW on x5; issue+wb in one cycle keeps the count.
    tbl.push_back(mk(1, w5, 1, 1, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, r7, 1, 1, 3, 0, 1, 1, 0, w5));
    tbl.push_back(mk(0, 0, 1, 1, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 5, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, xw, 1, 0, 0, 0, 1, 1, 0, r7));
    // x0 writer followed by x0 reader: no stall.
    tbl.push_back(mk(1, xr, 1, 1, 6, 0, 1, 1, 0, xw));
    tbl.push_back(mk(0, 0, 1, 1, 7, 0, 1, 1, 0, xr));
    tbl.push_back(mk(0, 0, 1, 1, 8, 0, 0, 1, 0, 0));
    // Backpressure from EX: offer stays stable, slot not overwritten.
    tbl.push_back(mk(1, ia, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, ib, 0, 0, 0, 0, 1, 0, 0, ia));
    tbl.push_back(mk(1, ib, 1, 0, 0, 0, 1, 1, 0, ia));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, ib));

    rst = 1'b1;
    idle_inputs();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], "tbl", i);

    // Flush during STALL with a same-cycle writeback.
    do_reset("rst1");
    run_vec(mk(1, w6, 1, 0, 0, 0, 0, 1, 0, 0), "fl", 0);
    run_vec(mk(1, w5, 1, 0, 0, 0, 1, 1, 0, w6), "fl", 1);
    run_vec(mk(1, r6, 1, 0, 0, 0, 1, 1, 0, w5), "fl", 2);
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0), "fl", 3);
    run_vec(mk(0, 0, 1, 1, 6, 1, 0, 0, 1, 0), "fl", 4);
    run_vec(mk(0, 0, 1, 1, 5, 0, 0, 0, 0, 0), "fl", 5);
    run_vec(mk(1, r8, 1, 0, 0, 0, 0, 1, 0, 0), "fl", 6);
    // x5 busy and outstanding count must both be gone after the flush.
    run_vec(mk(1, i1, 1, 0, 0, 0, 1, 1, 0, r8), "fl", 7);
    run_vec(mk(1, i2, 1, 0, 0, 0, 1, 1, 0, i1), "fl", 8);
    run_vec(mk(1, i3, 1, 0, 0, 0, 1, 1, 0, i2), "fl", 9);
    run_vec(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, i3), "fl", 10);
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0), "fl", 11);

    // Asynchronous reset while an offer is pending on a blocked EX.
    do_reset("rst2");
    run_vec(mk(1, ia, 0, 0, 0, 0, 0, 1, 0, 0), "ar", 0);
    run_vec(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, ia), "ar", 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("ar_mid");
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0), "ar", 2);
    run_vec(mk(1, i1, 1, 0, 0, 0, 0, 1, 0, 0), "ar", 3);
    run_vec(mk(1, i2, 1, 0, 0, 0, 1, 1, 0, i1), "ar", 4);
    run_vec(mk(1, i3, 1, 0, 0, 0, 1, 1, 0, i2), "ar", 5);
    run_vec(mk(1, i4, 1, 0, 0, 0, 1, 1, 0, i3), "ar", 6);
    run_vec(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, i4), "ar", 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
